ex_madd_seq: RTL and testbench

Multi-cycle sequencer for the EX-stage multiply-accumulate instructions (MADD, MADDU, MSUB, MSUBU). It adds or subtracts a 64-bit product to or from the HI/LO pair. It does this by time-multiplexing a single 32-bit adder with carry-in over two cycles: low word first, then high word. It sits beside the EX add/sub unit, stalls the pipeline while busy, and drives the HI/LO write port on completion.

---
 rtl/ex_madd_seq_pkg.sv | 36 +++
 rtl/ex_madd_seq_add32c.sv | 15 +
 rtl/ex_madd_seq.sv | 197 +++++++++++++++++++
 tb/tb_ex_madd_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_madd_seq_pkg.sv
// Shared definitions for the EX-stage multiply-accumulate sequencer:
// bus widths, ALU opcodes for the MADD family, FSM state encoding and
// small opcode-decode helpers.
package ex_madd_seq_pkg;

    localparam int RegBusW       = 32;
    localparam int DoubleRegBusW = 64;

    typedef logic [RegBusW-1:0]       RegBus;
    typedef logic [DoubleRegBusW-1:0] DoubleRegBus;
    typedef logic [7:0]               AluOpBus;

    localparam AluOpBus EXE_MADD_OP  = 8'b1010_0110;
    localparam AluOpBus EXE_MADDU_OP = 8'b1010_1000;
    localparam AluOpBus EXE_MSUB_OP  = 8'b1010_1010;
    localparam AluOpBus EXE_MSUBU_OP = 8'b1010_1011;

    typedef enum logic [1:0] {
        MaddIdle = 2'd0,
        MaddLo   = 2'd1,
        MaddHi   = 2'd2,
        MaddDone = 2'd3
    } madd_state_e;

    // True for any of the four multiply-accumulate opcodes.
    function automatic logic is_madd_op(input AluOpBus op);
        return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
               (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

    // True for the subtracting forms; signedness is already folded into the product.
    function automatic logic is_sub_op(input AluOpBus op);
        return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

endpackage

// File: rtl/ex_madd_seq_add32c.sv
// Combinational 32-bit adder with carry-in and carry-out. One instance is
// time-shared by the sequencer between the low-word and high-word steps.
module ex_add32c
    import ex_madd_seq_pkg::*;
(
    input  logic [RegBusW-1:0] i_a,
    input  logic [RegBusW-1:0] i_b,
    input  logic               i_cin,
    output logic [RegBusW-1:0] o_sum,
    output logic               o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{RegBusW{1'b0}}, i_cin};

endmodule

// File: rtl/ex_madd_seq.sv
// EX-stage multiply-accumulate sequencer (MADD/MADDU/MSUB/MSUBU).
// Adds or subtracts the 64-bit product to/from HI/LO, stalling EX while busy
// and pulsing the HI/LO write enable for one cycle on completion.
//
// Build option MADD_ONECYCLE_EN: when defined, the full 64-bit sum is formed
// in IDLE and the FSM jumps straight to DONE (1 stall cycle). When undefined,
// a single 32-bit adder is used twice, low word then high word (3 stall cycles).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a MADD-family opcode; operands captured on go
// LO    | low-word add, carry registered
// HI    | high-word add with registered carry, result registered
// DONE  | whilo_o high for this single cycle, EX allowed to advance
module ex_madd_seq
    import ex_madd_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [7:0]               aluop_i,
    input  logic [DoubleRegBusW-1:0] mul_i,
    input  logic [RegBusW-1:0]       hi_i,
    input  logic [RegBusW-1:0]       lo_i,
    output logic                     stallreq_o,
    output logic                     whilo_o,
    output logic [RegBusW-1:0]       hi_o,
    output logic [RegBusW-1:0]       lo_o
);

    madd_state_e r_state;
    madd_state_e w_state_nxt;

    logic w_go;
    logic w_sub;
    logic w_stall;
    logic w_capture;
    logic w_commit;

    logic               r_whilo;
    logic [RegBusW-1:0] r_hi_o;
    logic [RegBusW-1:0] r_lo_o;

    assign w_go  = is_madd_op(aluop_i);
    assign w_sub = is_sub_op(aluop_i);

`ifdef MADD_ONECYCLE_EN
    logic [DoubleRegBusW-1:0] w_b64;
    logic [DoubleRegBusW-1:0] w_sum64;

    // Subtraction is addition of the one's complement with carry-in 1.
    assign w_b64   = w_sub ? ~mul_i : mul_i;
    assign w_sum64 = {hi_i, lo_i} + w_b64 + {{(DoubleRegBusW-1){1'b0}}, w_sub};
`else
    logic [DoubleRegBusW-1:0] r_b;
    logic [RegBusW-1:0]       r_hi;
    logic [RegBusW-1:0]       r_lo;
    logic                     r_sub;
    logic                     r_carry;
    logic [RegBusW-1:0]       r_lo_res;

    logic               w_sel_hi;
    logic [RegBusW-1:0] w_add_a;
    logic [RegBusW-1:0] w_add_b;
    logic               w_add_cin;
    logic [RegBusW-1:0] w_add_sum;
    logic               w_add_cout;

    // The adder serves the low word in LO and the high word in HI.
    assign w_sel_hi  = (r_state == MaddHi);
    assign w_add_a   = w_sel_hi ? r_hi : r_lo;
    assign w_add_b   = w_sel_hi ? r_b[DoubleRegBusW-1:RegBusW] : r_b[RegBusW-1:0];
    assign w_add_cin = w_sel_hi ? r_carry : r_sub;

    ex_add32c u_add32c (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MaddIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stall request and capture/commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            MaddIdle: begin
                w_stall = w_go;
                if (w_go && !flush_i) begin
`ifdef MADD_ONECYCLE_EN
                    w_commit    = 1'b1;
                    w_state_nxt = MaddDone;
`else
                    w_capture   = 1'b1;
                    w_state_nxt = MaddLo;
`endif
                end
            end
`ifndef MADD_ONECYCLE_EN
            MaddLo: begin
                w_stall     = 1'b1;
                w_state_nxt = flush_i ? MaddIdle : MaddHi;
            end
            MaddHi: begin
                w_stall = 1'b1;
                if (flush_i) begin
                    w_state_nxt = MaddIdle;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = MaddDone;
                end
            end
`endif
            MaddDone: begin
                w_state_nxt = MaddIdle;
            end
            default: begin
                w_state_nxt = MaddIdle;
            end
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

`ifdef MADD_ONECYCLE_EN
    // Result registers; the whole sum is committed straight out of IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_whilo <= 1'b0;
            r_hi_o  <= '0;
            r_lo_o  <= '0;
        end else begin
            r_whilo <= w_commit;
            if (w_commit) begin
                r_hi_o <= w_sum64[DoubleRegBusW-1:RegBusW];
                r_lo_o <= w_sum64[RegBusW-1:0];
            end
        end
    end

    // The capture strobe has no consumer here; only the two-step build stores operands.
    logic w_unused;
    assign w_unused = w_capture;
`else
    // Operand capture, low-word staging and result commit. The low word is
    // held internally until HI so a flush in LO leaves hi_o/lo_o untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_lo_res <= '0;
            r_whilo  <= 1'b0;
            r_hi_o   <= '0;
            r_lo_o   <= '0;
        end else begin
            r_whilo <= w_commit;
            if (w_capture) begin
                r_b   <= w_sub ? ~mul_i : mul_i;
                r_hi  <= hi_i;
                r_lo  <= lo_i;
                r_sub <= w_sub;
            end
            if (r_state == MaddLo) begin
                r_carry  <= w_add_cout;
                r_lo_res <= w_add_sum;
            end
            if (w_commit) begin
                r_hi_o <= w_add_sum;
                r_lo_o <= r_lo_res;
            end
        end
    end
`endif

    assign stallreq_o = w_stall;
    assign whilo_o    = r_whilo;
    assign hi_o       = r_hi_o;
    assign lo_o       = r_lo_o;

endmodule

// File: tb/tb_ex_madd_seq.sv
// Self-checking bench for ex_madd_seq. The reference is plain 64-bit
// arithmetic on {HI,LO}; cycle timing is checked per cycle of each operation.
module tb_ex_madd_seq;
    import ex_madd_seq_pkg::*;

`ifdef MADD_ONECYCLE_EN
    localparam int STALLS = 1;
`else
    localparam int STALLS = 3;
`endif
    localparam logic [7:0] NOP_OP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [63:0] mul_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    ex_madd_seq dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .aluop_i    (aluop_i),
        .mul_i      (mul_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .stallreq_o (stallreq_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] mul,
                                          input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] acc;
        acc = {hi, lo};
        if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) return acc - mul;
        return acc + mul;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the current cycle (called at posedge+1) and follow
    // it to completion; returns at posedge+1 of the cycle after DONE.
    task automatic run_op(input logic [7:0] op, input logic [63:0] mul, input logic [31:0] hi,
                          input logic [31:0] lo, input string tag, output int pulse_cyc);
        logic [63:0] expv;
        expv      = model(op, mul, hi, lo);
        pulse_cyc = -1;
        aluop_i   = op;
        mul_i     = mul;
        hi_i      = hi;
        lo_i      = lo;
        for (int k = 0; k <= STALLS; k++) begin
            #1;
            chk({tag, "/stall"}, 64'(stallreq_o), 64'(k < STALLS));
            chk({tag, "/whilo"}, 64'(whilo_o), 64'(k == STALLS));
            if (k == STALLS) begin
                if (whilo_o === 1'b1) pulse_cyc = cyc_cnt;
                chk({tag, "/hi"}, 64'(hi_o), 64'(expv[63:32]));
                chk({tag, "/lo"}, 64'(lo_o), 64'(expv[31:0]));
            end
            @(posedge clk);
            #1;
            if (k == 0) begin
                mul_i = {$urandom, $urandom};
                hi_i  = $urandom;
                lo_i  = $urandom;
            end
        end
        last_hi = expv[63:32];
        last_lo = expv[31:0];
    endtask

    // Idle cycles: no write, no stall, results held.
    task automatic idle(input int n, input string tag);
        aluop_i = NOP_OP;
        for (int k = 0; k < n; k++) begin
            #1;
            chk({tag, "/idle_whilo"}, 64'(whilo_o), 64'd0);
            chk({tag, "/idle_stall"}, 64'(stallreq_o), 64'd0);
            chk({tag, "/hold_hi"}, 64'(hi_o), 64'(last_hi));
            chk({tag, "/hold_lo"}, 64'(lo_o), 64'(last_lo));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int p1;
        int p2;
        logic [7:0] ops [4];
        ops = '{EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};

        rst     = 1'b1;
        flush_i = 1'b0;
        aluop_i = EXE_MADD_OP;
        mul_i   = 64'h1234_5678_9abc_def0;
        hi_i    = 32'h1111_1111;
        lo_i    = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/stall", 64'(stallreq_o), 64'd0);
        chk("reset/whilo", 64'(whilo_o), 64'd0);
        chk("reset/hi", 64'(hi_o), 64'd0);
        chk("reset/lo", 64'(lo_o), 64'd0);
        rst = 1'b0;
        idle(2, "post_reset");

        run_op(EXE_MADDU_OP, 64'h0000_0000_0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, "maddu_carry", p1);
        idle(1, "maddu_carry");
        run_op(EXE_MSUB_OP, 64'h1, 32'h0, 32'h0, "msub_borrow", p1);
        idle(1, "msub_borrow");
        run_op(EXE_MADD_OP, 64'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "madd_wrap", p1);
        idle(1, "madd_wrap");

`ifndef MADD_ONECYCLE_EN
        aluop_i = EXE_MADDU_OP;
        mul_i   = 64'h0000_0005_0000_0007;
        hi_i    = 32'h10;
        lo_i    = 32'h20;
        #1;
        chk("flush/c0_stall", 64'(stallreq_o), 64'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("flush/lo_stall", 64'(stallreq_o), 64'd1);
        chk("flush/lo_whilo", 64'(whilo_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        aluop_i = NOP_OP;
        idle(4, "flush");
        run_op(EXE_MADDU_OP, 64'h0000_0005_0000_0007, 32'h10, 32'h20, "after_flush", p1);
        idle(1, "after_flush");
`endif

        run_op(EXE_MADD_OP, 64'd3, 32'd0, 32'd5, "b2b_madd", p1);
        run_op(EXE_MSUB_OP, 64'd3, 32'd0, 32'd5, "b2b_msub", p2);
        chk("b2b/gap", 64'(p2 - p1), 64'(STALLS + 1));
        idle(1, "b2b");

        aluop_i = EXE_MSUBU_OP;
        mul_i   = 64'hDEAD_BEEF_0BAD_F00D;
        hi_i    = 32'hCAFE_0000;
        lo_i    = 32'h0000_BABE;
        for (int k = 0; k < STALLS - 1; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid/stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        aluop_i = NOP_OP;
        #1;
        chk("rst_mid/whilo", 64'(whilo_o), 64'd0);
        chk("rst_mid/hi", 64'(hi_o), 64'd0);
        chk("rst_mid/lo", 64'(lo_o), 64'd0);
        chk("rst_mid/stall_idle", 64'(stallreq_o), 64'd0);
        last_hi = '0;
        last_lo = '0;
        @(posedge clk);
        #1;
        idle(3, "rst_mid");
        run_op(EXE_MADDU_OP, 64'h0000_0001_FFFF_FFFF, 32'h1, 32'h1, "after_rst", p1);

        for (int n = 0; n < 30; n++) begin
            run_op(ops[$urandom_range(0, 3)], {$urandom, $urandom}, $urandom, $urandom, "rand", p1);
            idle(int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
